add_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs a wide add (8*WORDS bits) by issuing one 8-bit slice per cycle to a single shared 8-bit adder slice. The carry-out of each slice is registered and fed back as the carry-in of the next slice. It sits between a valid/ready operand source and a valid/ready result sink, trading latency for adder area.

---
 rtl/add_seq_pkg.sv | 14 +
 rtl/add8_slice.sv | 14 +
 rtl/add_seq_ctrl.sv | 113 +++++++++++
 tb/tb_add_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types for the slice-serial wide adder: slice width, FSM states, slice type.
package add_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  typedef logic [SLICE_W-1:0] slice_t;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit adder slice with carry-in/carry-out; the only adder in the sequencer.
module add8_slice
  import add_seq_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   cin,
  output slice_t sum,
  output logic   cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Slice-serial wide adder: one 8-bit slice per cycle through a shared add8_slice,
// with the slice carry registered between cycles. valid/ready on both sides.
// Optional macro ADD_SUB_EN adds a 'sub' input selecting A-B (two's complement).
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*WORDS-1:0]     a,
  input  logic [8*WORDS-1:0]     b,
  input  logic                   cin,
`ifdef ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*WORDS-1:0]     sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  add_seq_state_t          state;
  logic [IW-1:0]           idx;
  logic                    carry;
  slice_t [WORDS-1:0]      a_r;
  slice_t [WORDS-1:0]      b_r;
  slice_t [WORDS-1:0]      sum_r;
  logic                    cout_r;
  logic                    out_valid_r;

  slice_t                  s_sum;
  logic                    s_cout;

  // Operand B and the carry seed as they should be latched on accept; for
  // subtraction B is inverted once here so the slice always just adds.
  logic [8*WORDS-1:0]      b_eff;
  logic                    carry_seed;

`ifdef ADD_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_seed = sub ? 1'b1 : cin;
`else
  assign b_eff      = b;
  assign carry_seed = cin;
`endif

  add8_slice u_slice (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Sequencer: accept operands, walk the slices low to high, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b_eff;
            carry <= carry_seed;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= s_sum;
          carry      <= s_cout;
          if (idx == LAST_IDX) begin
            cout_r      <= s_cout;
            out_valid_r <= 1'b1;
            idx         <= '0;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl (WORDS=4): directed and randomized operations checked
// against a plain-arithmetic model of the wide add.
module tb_add_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Present one operand set for a single accept edge, scramble the inputs
  // afterwards, and wait (bounded) for out_valid. Caller is 1 time unit past an edge, DUT idle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] s, output logic c, output int lat);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum; c = cout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (sum !== '0)         begin bad++; $display("FAIL reset_sum got=%h exp=0", sum); end
    total++; if (cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] s; logic c; int lat;
    out_ready = 1'b1;
    run_op(32'h000000FF, 32'h00000001, 1'b0, s, c, lat);
    total++; if (lat !== 4)              begin bad++; $display("FAIL dir1_latency got=%0d exp=4", lat); end
    total++; if (s !== 32'h00000100)     begin bad++; $display("FAIL dir1_sum got=%h exp=00000100", s); end
    total++; if (c !== 1'b0)             begin bad++; $display("FAIL dir1_cout got=%b exp=0", c); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL dir1_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, s, c, lat);
    total++; if (lat !== 4)              begin bad++; $display("FAIL dir2_latency got=%0d exp=4", lat); end
    total++; if (s !== 32'h00000000)     begin bad++; $display("FAIL dir2_sum got=%h exp=00000000", s); end
    total++; if (c !== 1'b1)             begin bad++; $display("FAIL dir2_cout got=%b exp=1", c); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] s, av, bv; logic c, cv; logic [W:0] exp; int lat, d;
    for (int i = 0; i < 24; i++) begin
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom_range(0, 1));
      if (i % 6 == 0) bv = ~av;
      exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      d = $urandom_range(0, 3);
      out_ready = (d == 0);
      run_op(av, bv, cv, s, c, lat);
      total++; if (lat !== 4)          begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=4", i, lat); end
      total++; if (s !== exp[W-1:0])   begin bad++; $display("FAIL rnd_sum[%0d] got=%h exp=%h", i, s, exp[W-1:0]); end
      total++; if (c !== exp[W])       begin bad++; $display("FAIL rnd_cout[%0d] got=%b exp=%b", i, c, exp[W]); end
      if (d > 0) begin
        repeat (d) begin @(posedge clk); #1; end
        total++; if (out_valid !== 1'b1 || sum !== exp[W-1:0]) begin
          bad++; $display("FAIL rnd_hold[%0d] got valid=%b sum=%h exp valid=1 sum=%h", i, out_valid, sum, exp[W-1:0]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL rnd_release[%0d] got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; int ready_seen;
    out_ready = 1'b1;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h80000000; b = 32'h80000000; cin = 1'b0;
    lat = 0; ready_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ready_seen++;
    total++; if (lat !== 4)            begin bad++; $display("FAIL b2b_lat1 got=%0d exp=4", lat); end
    total++; if (ready_seen !== 0)     begin bad++; $display("FAIL b2b_in_ready_busy got=%0d cycles high exp=0", ready_seen); end
    total++; if (sum !== 32'h23456789 || cout !== 1'b0) begin
      bad++; $display("FAIL b2b_res1 got=%h/%b exp=23456789/0", sum, cout);
    end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 4)            begin bad++; $display("FAIL b2b_lat2 got=%0d exp=4", lat); end
    total++; if (sum !== 32'h00000000 || cout !== 1'b1) begin
      bad++; $display("FAIL b2b_res2 got=%h/%b exp=00000000/1", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic c; logic [W:0] exp; int lat; int seen;
    out_ready = 1'b0;
    exp = {1'b0, 32'hA5A5A5A5} + {1'b0, 32'h5A5A5A5B};
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, s, c, lat);
    total++; if (lat !== 4)        begin bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    a = 32'h00000001; b = 32'h00000002; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || sum !== exp[W-1:0] || cout !== exp[W] || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got valid=%b sum=%h cout=%b in_ready=%b exp 1/%h/%b/0",
                        i, out_valid, sum, cout, in_ready, exp[W-1:0], exp[W]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
    total++; if (seen !== 0)       begin bad++; $display("FAIL bp_no_accept got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_reset_mid_run();
    int seen; logic [W-1:0] s; logic c; int lat;
    out_ready = 1'b1;
    a = W'($urandom) | 32'h01010101; b = W'($urandom); cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_outputs got valid=%b sum=%h cout=%b busy=%b in_ready=%b exp 0/0/0/0/1",
                      out_valid, sum, cout, busy, in_ready);
    end
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++; if (seen !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_abort got out_valid cycles=%0d in_ready=%b exp 0/1", seen, in_ready);
    end
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, s, c, lat);
    total++; if (lat !== 4 || s !== 32'h00010000 || c !== 1'b0) begin
      bad++; $display("FAIL midrst_recover got lat=%0d sum=%h cout=%b exp 4/00010000/0", lat, s, c);
    end
    @(posedge clk); #1;
  endtask

`ifdef ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s, av, bv; logic c; logic [W:0] exp; int lat;
    out_ready = 1'b1;
    sub = 1'b1;
    run_op(32'd5, 32'd7, 1'($urandom_range(0, 1)), s, c, lat);
    total++; if (s !== 32'hFFFFFFFE || c !== 1'b0) begin bad++; $display("FAIL sub_5m7 got=%h/%b exp=FFFFFFFE/0", s, c); end
    @(posedge clk); #1;
    sub = 1'b1;
    run_op(32'd7, 32'd5, 1'b0, s, c, lat);
    total++; if (s !== 32'h00000002 || c !== 1'b1) begin bad++; $display("FAIL sub_7m5 got=%h/%b exp=00000002/1", s, c); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      av = W'($urandom); bv = W'($urandom);
      exp = {1'b0, av} + {1'b0, ~bv} + 1;
      sub = 1'b1;
      run_op(av, bv, 1'($urandom_range(0, 1)), s, c, lat);
      total++; if (s !== exp[W-1:0] || c !== exp[W] || lat !== 4) begin
        bad++; $display("FAIL sub_rnd[%0d] got=%h/%b lat=%0d exp=%h/%b lat=4", i, s, c, lat, exp[W-1:0], exp[W]);
      end
      @(posedge clk); #1;
    end
    sub = 1'b0;
    run_op(32'h00000010, 32'h00000020, 1'b1, s, c, lat);
    total++; if (s !== 32'h00000031 || c !== 1'b0) begin bad++; $display("FAIL sub0_add got=%h/%b exp=00000031/0", s, c); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
